// File: rtl/rapid_pkg.sv
// Shared request encodings for the cache responder and its initiators.
package rapid_pkg;

    typedef enum logic {
        CACHE_READ  = 1'b0,
        CACHE_WRITE = 1'b1
    } cache_rw;

    typedef enum logic [1:0] {
        CACHE_NOP    = 2'd0,
        QUARTER_WORD = 2'd1,
        HALF_WORD    = 2'd2,
        WORD         = 2'd3
    } cache_operation;

endpackage

// File: rtl/cache_responder.sv
// cache_responder: fixed-latency, single-outstanding responder backed by a word array.
//
// A request is accepted when req_valid_i and req_ready_o are both high. Its response
// appears LATENCY cycles later as a one-cycle resp_valid_o pulse, and the responder
// returns to idle on the cycle after that. Writes commit at the end of the response
// cycle, so any read accepted afterwards sees them.
//
// Optional feature macro: CACHE_RESP_MISALIGN_TRAP_EN
//   defined   -> misaligned HALF_WORD/WORD accesses return resp_err_o=1, rdata 0, no write
//   undefined -> offending low address bits are cleared and the access proceeds
//
// Ports:
//   clk_i          clock, rising edge
//   rst_ni         asynchronous active-low reset (array contents are not reset)
//   req_valid_i    request present
//   req_ready_o    responder idle and able to accept
//   req_rw_i       CACHE_READ / CACHE_WRITE
//   req_op_i       CACHE_NOP / QUARTER_WORD / HALF_WORD / WORD
//   req_unsigned_i zero-extend read data when 1, sign-extend when 0
//   req_addr_i     byte address; bits above the array index are ignored
//   req_wdata_i    right-justified write data
//   resp_valid_o   one-cycle response pulse
//   resp_rdata_o   extended read data (0 for writes, NOPs and while idle)
//   resp_err_o     misaligned access flag
module cache_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  rapid_pkg::cache_rw         req_rw_i,
    input  rapid_pkg::cache_operation  req_op_i,
    input  logic                       req_unsigned_i,
    input  logic [31:0]                req_addr_i,
    input  logic [31:0]                req_wdata_i,
    output logic                       resp_valid_o,
    output logic [31:0]                resp_rdata_o,
    output logic                       resp_err_o
);
    import rapid_pkg::*;

    localparam int unsigned IdxW       = $clog2(DEPTH_WORDS);
    localparam int unsigned AddrW      = IdxW + 2;
    // Cycles spent in BUSY; unused when LATENCY is 1 but kept non-zero for sizing.
    localparam int unsigned BusyCycles = (LATENCY > 1) ? LATENCY - 1 : 1;
    localparam int unsigned CntW       = (BusyCycles > 1) ? $clog2(BusyCycles) : 1;

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e              state_q;
    logic [CntW-1:0]     cnt_q;
    logic                req_ready_q;
    logic                resp_valid_q;
    logic [31:0]         resp_rdata_q;
    logic                resp_err_q;

    cache_rw             rw_q;
    cache_operation      op_q;
    logic                uns_q;
    logic [AddrW-1:0]    addr_q;
    logic [31:0]         wdata_q;

    logic [31:0]         mem_q [DEPTH_WORDS];

    logic                accept;
    cache_rw             cur_rw;
    cache_operation      cur_op;
    logic                cur_uns;
    logic [AddrW-1:0]    cur_addr;
    logic [AddrW-1:0]    eff_addr;
    logic [31:0]         rd_word;
    logic [7:0]          rd_byte;
    logic [15:0]         rd_half;
    logic [31:0]         rsp_rdata;
    logic                rsp_err;
    logic                wr_en;
    logic [3:0]          wr_be;
    logic [31:0]         wr_data;

    // Address bits above the index wrap away by design.
    logic unused_addr;
    assign unused_addr = ^req_addr_i[31:AddrW];

    assign accept = req_valid_i && req_ready_q;

    // While idle the live request drives the datapath (needed for LATENCY=1);
    // otherwise the captured request does.
    always_comb begin
        if (state_q == StIdle) begin
            cur_rw   = req_rw_i;
            cur_op   = req_op_i;
            cur_uns  = req_unsigned_i;
            cur_addr = req_addr_i[AddrW-1:0];
        end else begin
            cur_rw   = rw_q;
            cur_op   = op_q;
            cur_uns  = uns_q;
            cur_addr = addr_q;
        end
    end

    always_comb begin
        eff_addr = cur_addr;
        rsp_err  = 1'b0;
`ifdef CACHE_RESP_MISALIGN_TRAP_EN
        rsp_err = ((cur_op == HALF_WORD) && cur_addr[0]) ||
                  ((cur_op == WORD) && (cur_addr[1:0] != 2'b00));
`else
        if (cur_op == HALF_WORD) begin
            eff_addr[0] = 1'b0;
        end else if (cur_op == WORD) begin
            eff_addr[1:0] = 2'b00;
        end
`endif
        rd_word = mem_q[eff_addr[AddrW-1:2]];
        rd_byte = rd_word[{eff_addr[1:0], 3'b000} +: 8];
        rd_half = rd_word[{eff_addr[1], 4'b0000} +: 16];

        rsp_rdata = '0;
        if (cur_rw == CACHE_READ && !rsp_err) begin
            unique case (cur_op)
                CACHE_NOP:    rsp_rdata = '0;
                QUARTER_WORD: rsp_rdata = cur_uns ? {24'b0, rd_byte}
                                                  : {{24{rd_byte[7]}}, rd_byte};
                HALF_WORD:    rsp_rdata = cur_uns ? {16'b0, rd_half}
                                                  : {{16{rd_half[15]}}, rd_half};
                WORD:         rsp_rdata = rd_word;
            endcase
        end
    end

    // Write lanes; in RESP the datapath is driven by the captured request.
    always_comb begin
        wr_en   = (state_q == StResp) && (rw_q == CACHE_WRITE) && !rsp_err &&
                  (op_q != CACHE_NOP);
        wr_be   = 4'b0000;
        wr_data = '0;
        unique case (op_q)
            CACHE_NOP: begin
                wr_be   = 4'b0000;
                wr_data = '0;
            end
            QUARTER_WORD: begin
                wr_be   = 4'b0001 << eff_addr[1:0];
                wr_data = {4{wdata_q[7:0]}};
            end
            HALF_WORD: begin
                wr_be   = eff_addr[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{wdata_q[15:0]}};
            end
            WORD: begin
                wr_be   = 4'b1111;
                wr_data = wdata_q;
            end
        endcase
    end

    // Array is deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem_q[eff_addr[AddrW-1:2]][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            rw_q         <= CACHE_READ;
            op_q         <= CACHE_NOP;
            uns_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    req_ready_q <= 1'b1;
                    if (accept) begin
                        rw_q        <= req_rw_i;
                        op_q        <= req_op_i;
                        uns_q       <= req_unsigned_i;
                        addr_q      <= req_addr_i[AddrW-1:0];
                        wdata_q     <= req_wdata_i;
                        req_ready_q <= 1'b0;
                        if (LATENCY <= 1) begin
                            state_q      <= StResp;
                            resp_valid_q <= 1'b1;
                            resp_rdata_q <= rsp_rdata;
                            resp_err_q   <= rsp_err;
                        end else begin
                            state_q <= StBusy;
                            cnt_q   <= CntW'(BusyCycles - 1);
                        end
                    end
                end
                StBusy: begin
                    if (cnt_q == '0) begin
                        state_q      <= StResp;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= rsp_rdata;
                        resp_err_q   <= rsp_err;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StResp: begin
                    state_q     <= StIdle;
                    req_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= StIdle;
                    req_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o  = req_ready_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = resp_rdata_q;
    assign resp_err_o   = resp_err_q;

endmodule

// File: tb/tb_cache_responder.sv
// Directed bench for cache_responder (DEPTH_WORDS=256, LATENCY=2).
module tb_cache_responder;
    import rapid_pkg::*;

    logic           clk;
    logic           rst_n;
    logic           req_valid;
    logic           req_ready;
    cache_rw        req_rw;
    cache_operation req_op;
    logic           req_unsigned;
    logic [31:0]    req_addr;
    logic [31:0]    req_wdata;
    logic           resp_valid;
    logic [31:0]    resp_rdata;
    logic           resp_err;

    int checks = 0;
    int errors = 0;

    logic [31:0] got_rdata;
    logic        got_err;
    int          got_lat;
    logic        seen_valid;

    cache_responder #(
        .DEPTH_WORDS(256),
        .LATENCY    (2)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_rw_i      (req_rw),
        .req_op_i      (req_op),
        .req_unsigned_i(req_unsigned),
        .req_addr_i    (req_addr),
        .req_wdata_i   (req_wdata),
        .resp_valid_o  (resp_valid),
        .resp_rdata_o  (resp_rdata),
        .resp_err_o    (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one request from an idle responder and collect its response.
    // Called #1 after a rising edge; returns #1 after the edge following the response.
    task automatic do_req(input string tag, input cache_rw rw, input cache_operation op,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat);
        check({tag, ".ready"}, {31'b0, req_ready}, 32'd1);
        req_valid    = 1'b1;
        req_rw       = rw;
        req_op       = op;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_rw    = CACHE_READ;
        req_op    = CACHE_NOP;
        req_addr  = 32'hFFFF_FFFF;
        req_wdata = 32'hFFFF_FFFF;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rdata = resp_rdata;
        err   = resp_err;
        check({tag, ".lat"}, lat, 32'd2);
        @(posedge clk);
        #1;
        check({tag, ".pulse"}, {31'b0, resp_valid}, 32'd0);
        check({tag, ".idle_rdata"}, resp_rdata, 32'd0);
    endtask

    task automatic rd(input string tag, input cache_operation op, input logic uns,
                      input logic [31:0] addr, input logic [31:0] exp_data, input logic exp_err);
        do_req(tag, CACHE_READ, op, uns, addr, 32'h0, got_rdata, got_err, got_lat);
        check({tag, ".rdata"}, got_rdata, exp_data);
        check({tag, ".err"}, {31'b0, got_err}, {31'b0, exp_err});
    endtask

    task automatic wr(input string tag, input cache_operation op, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic exp_err);
        do_req(tag, CACHE_WRITE, op, 1'b0, addr, wdata, got_rdata, got_err, got_lat);
        check({tag, ".rdata"}, got_rdata, 32'd0);
        check({tag, ".err"}, {31'b0, got_err}, {31'b0, exp_err});
    endtask

    logic misalign_trap;

    initial begin
`ifdef CACHE_RESP_MISALIGN_TRAP_EN
        misalign_trap = 1'b1;
`else
        misalign_trap = 1'b0;
`endif
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_rw       = CACHE_READ;
        req_op       = CACHE_NOP;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;

        // Reset state
        #12;
        check("rst.ready", {31'b0, req_ready}, 32'd0);
        check("rst.valid", {31'b0, resp_valid}, 32'd0);
        check("rst.rdata", resp_rdata, 32'd0);
        check("rst.err", {31'b0, resp_err}, 32'd0);
        rst_n = 1'b1;
        #2;
        check("rel.ready_before_edge", {31'b0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        check("rel.ready_after_edge", {31'b0, req_ready}, 32'd1);

        // Basic word write / read
        wr("w_word_10", WORD, 32'h10, 32'hDEAD_BEEF, 1'b0);
        rd("r_word_10", WORD, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0);

        // Byte and halfword extension
        rd("r_qw_13_s", QUARTER_WORD, 1'b0, 32'h13, 32'hFFFF_FFDE, 1'b0);
        rd("r_qw_13_u", QUARTER_WORD, 1'b1, 32'h13, 32'h0000_00DE, 1'b0);
        rd("r_qw_10_s", QUARTER_WORD, 1'b0, 32'h10, 32'hFFFF_FFEF, 1'b0);
        rd("r_qw_11_u", QUARTER_WORD, 1'b1, 32'h11, 32'h0000_00BE, 1'b0);
        rd("r_hw_10_s", HALF_WORD, 1'b0, 32'h10, 32'hFFFF_BEEF, 1'b0);
        rd("r_hw_12_u", HALF_WORD, 1'b1, 32'h12, 32'h0000_DEAD, 1'b0);
        rd("r_word_uns", WORD, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);

        // Halfword write leaves other lanes alone; upper wdata bits ignored
        wr("w_hw_12", HALF_WORD, 32'h12, 32'hABCD_1234, 1'b0);
        rd("r_word_10b", WORD, 1'b0, 32'h10, 32'h1234_BEEF, 1'b0);

        // Misaligned word read
        if (misalign_trap) rd("r_mis_11", WORD, 1'b0, 32'h11, 32'h0, 1'b1);
        else               rd("r_mis_11", WORD, 1'b0, 32'h11, 32'h1234_BEEF, 1'b0);
        if (misalign_trap) rd("r_mis_hw_11", HALF_WORD, 1'b1, 32'h11, 32'h0, 1'b1);
        else               rd("r_mis_hw_11", HALF_WORD, 1'b1, 32'h11, 32'h0000_BEEF, 1'b0);

        // Misaligned word write: trapped (no write) or forced aligned
        wr("w_word_30", WORD, 32'h30, 32'h0000_0000, 1'b0);
        wr("w_mis_31", WORD, 32'h31, 32'hCAFE_F00D, misalign_trap);
        rd("r_word_30", WORD, 1'b0, 32'h30, misalign_trap ? 32'h0 : 32'hCAFE_F00D, 1'b0);

        // Byte write to lane 3
        wr("w_word_40", WORD, 32'h40, 32'h0000_0000, 1'b0);
        wr("w_qw_43", QUARTER_WORD, 32'h43, 32'hFFFF_FF77, 1'b0);
        rd("r_word_40", WORD, 1'b0, 32'h40, 32'h7700_0000, 1'b0);

        // Address wrap
        wr("w_word_400", WORD, 32'h400, 32'h0000_0055, 1'b0);
        rd("r_word_0", WORD, 1'b0, 32'h0, 32'h0000_0055, 1'b0);

        // NOP: normal latency, zero data, no write even with rw=WRITE
        rd("nop_rd", CACHE_NOP, 1'b0, 32'h10, 32'h0, 1'b0);
        do_req("nop_wr", CACHE_WRITE, CACHE_NOP, 1'b0, 32'h0, 32'hFFFF_FFFF,
               got_rdata, got_err, got_lat);
        check("nop_wr.rdata", got_rdata, 32'd0);
        rd("r_word_0b", WORD, 1'b0, 32'h0, 32'h0000_0055, 1'b0);

        // Reset during BUSY drops the write
        wr("w_word_20", WORD, 32'h20, 32'hA5A5_A5A5, 1'b0);
        req_valid = 1'b1;
        req_rw    = CACHE_WRITE;
        req_op    = WORD;
        req_addr  = 32'h20;
        req_wdata = 32'h1111_1111;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        check("mid_rst.ready", {31'b0, req_ready}, 32'd0);
        check("mid_rst.valid", {31'b0, resp_valid}, 32'd0);
        #2;
        rst_n = 1'b1;
        seen_valid = 1'b0;
        #4;
        check("mid_rst.ready_pre_edge", {31'b0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        check("mid_rst.ready_one_edge", {31'b0, req_ready}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            if (resp_valid) seen_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        check("mid_rst.no_resp", {31'b0, seen_valid}, 32'd0);
        rd("r_word_20", WORD, 1'b0, 32'h20, 32'hA5A5_A5A5, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global guard against a hung run.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cache_responder.md
CACHE_RESPONDER -- requirements
Module: cache_responder

Interface
REQ-001 SHALL have parameter: DEPTH_WORDS, 256, number of 32-bit words in the backing array (power of two, at least 4).
REQ-002 SHALL have parameter: LATENCY, 2, cycles from request accept to response (at least 1).
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port: rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port: req_valid  input  1  initiator presents a request.
REQ-006 SHALL have port: req_ready  output  1  responder can accept a request.
REQ-007 SHALL have port: req_rw  input  rapid_pkg::cache_rw  CACHE_READ or CACHE_WRITE.
REQ-008 SHALL have port: req_op  input  rapid_pkg::cache_operation  CACHE_NOP, QUARTER_WORD, HALF_WORD or WORD.
REQ-009 SHALL have port: req_unsigned  input  1  zero-extend read data (LBU, LHU); 0 means sign-extend.
REQ-010 SHALL have port: req_addr  input  32  byte address.
REQ-011 SHALL have port: req_wdata  input  32  write data, right-justified.
REQ-012 SHALL have port: resp_valid  output  1  one-cycle response pulse.
REQ-013 SHALL have port: resp_rdata  output  32  extended read data, valid with resp_valid.
REQ-014 SHALL have port: resp_err  output  1  misaligned access, valid with resp_valid.

Function
REQ-015 SHALL implement FSM states IDLE, BUSY and RESP.
REQ-016 SHALL drive req_ready high only in IDLE.
REQ-017 SHALL accept a request, capturing all req_* fields, on a cycle T where req_valid and req_ready are both high, then move to BUSY.
REQ-018 SHALL enter RESP and assert resp_valid for exactly one cycle, at cycle T+LATENCY; for LATENCY=1, BUSY is skipped.
REQ-019 SHALL return from RESP to IDLE, so req_ready is high at T+LATENCY+1; there is no response backpressure.
REQ-020 SHALL ignore req_* inputs while not in IDLE.
REQ-021 SHALL index the array with addr[2 +: log2(DEPTH_WORDS)]; upper address bits are ignored and the address wraps.
REQ-022 SHALL commit a write in the RESP cycle, using byte lanes as follows.
  - QUARTER_WORD: wdata[7:0] to lane addr[1:0].
  - HALF_WORD: wdata[15:0] to lanes {addr[1],0} and {addr[1],1}.
  - WORD: all four lanes.
  - All other lanes SHALL be left unchanged.
REQ-023 SHALL produce read data as follows.
  - QUARTER_WORD: selected byte extended to 32 bits per req_unsigned.
  - HALF_WORD: selected halfword extended to 32 bits per req_unsigned.
  - WORD: the full word; req_unsigned is ignored.
REQ-024 SHALL make a write visible to any read accepted after that write's response.
REQ-025 SHALL respond to CACHE_NOP with normal latency, resp_rdata=0, resp_err=0 and no write.
REQ-026 SHALL drive resp_rdata=0 for a write response and whenever resp_valid is low.

Reset
REQ-027 SHALL, while rst_n is low, force state IDLE, req_ready=0, resp_valid=0, resp_rdata=0 and resp_err=0.
REQ-028 SHALL raise req_ready at the first rising edge after rst_n deasserts.
REQ-029 SHALL, when reset asserts during BUSY or RESP, drop the transaction with no response; a write not yet committed SHALL NOT be committed.
REQ-030 SHALL NOT reset the array contents.

Configuration
REQ-031 SHALL use macro CACHE_RESP_MISALIGN_TRAP_EN to select misaligned-access handling.
  - Misaligned means HALF_WORD with addr[0]=1, or WORD with addr[1:0]!=0.
REQ-032 SHALL, with CACHE_RESP_MISALIGN_TRAP_EN defined, respond to a misaligned access with resp_err=1, resp_rdata=0, no write and normal latency.
REQ-033 SHALL, without CACHE_RESP_MISALIGN_TRAP_EN defined, force the offending low address bits to 0, perform the access, and tie resp_err to 0.

Verification (LATENCY=2, DEPTH_WORDS=256)
REQ-034 SHALL test: write WORD 0xDEADBEEF at 0x10, accepted at T, then read WORD at 0x10 -> write resp_valid at T+2; read resp_rdata=0xDEADBEEF exactly 2 cycles after its accept.
REQ-035 SHALL test: read QUARTER_WORD at 0x13 -> 0xFFFFFFDE with req_unsigned=0, and 0x000000DE with req_unsigned=1.
REQ-036 SHALL test: write HALF_WORD 0x1234 at 0x12 over 0xDEADBEEF, then read WORD at 0x10 -> 0x1234BEEF.
REQ-037 SHALL test: WORD read at 0x11 -> with macro, resp_err=1 and resp_rdata=0; without macro, resp_err=0 and resp_rdata=0x1234BEEF.
REQ-038 SHALL test: write WORD 0x55 at 0x400 -> read at 0x0 returns 0x55 (wrap).
REQ-039 SHALL test: rst_n pulsed low at T+1 of a write to 0x20 -> no resp_valid, word 0x20 unchanged, req_ready=1 one edge after release.
